// File: rtl/hazard_scoreboard_if.sv
// ID-stage to hazard scoreboard bundle: decoded instruction info in, issue
// control, forwarding selects and MDU write-port status out.
interface hazard_scoreboard_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       id_is_mdu;
    logic       id_flush;
    logic       stall;
    logic       issue;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mdu_busy;
    logic       mdu_wr;
    logic [4:0] mdu_rd;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_reg_write, id_is_load, id_is_mdu, id_flush,
        input  stall, issue, fwd_a, fwd_b, mdu_busy, mdu_wr, mdu_rd
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_reg_write, id_is_load, id_is_mdu, id_flush,
        output stall, issue, fwd_a, fwd_b, mdu_busy, mdu_wr, mdu_rd
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Issue controller for the 5-stage MIPS core: tracks EX/MEM/WB destinations and the
// outstanding MDU result, stalls decode, selects forwarding and schedules MDU write-back.
module hazard_scoreboard #(
    parameter int MDU_LAT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   bus
);
    localparam int CNT_W = (MDU_LAT < 2) ? 1 : $clog2(MDU_LAT);
    // The counter starts one short of MDU_LAT because the issue edge itself
    // is the first elapsed cycle; ready then lands exactly MDU_LAT cycles after issue.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

    logic             r_ex_valid, r_ex_reg_write, r_ex_is_load;
    logic [4:0]       r_ex_rd;
    logic             r_mem_valid, r_mem_reg_write;
    logic [4:0]       r_mem_rd;
    logic             r_wb_valid, r_wb_reg_write;
    logic [4:0]       r_wb_rd;
    logic             r_mdu_pending;
    logic [4:0]       r_mdu_rd;
    logic [CNT_W-1:0] r_mdu_cnt;
    logic [1:0]       r_fwd_a, r_fwd_b;

    logic [4:0]       w_src [2];
    logic [1:0]       w_use;
    logic [1:0]       w_ex_match, w_mem_match, w_mdu_match;
    logic [1:0][1:0]  w_fwd_next;
    logic             w_ex_wr, w_mem_wr, w_wb_wr;
    logic             w_s1, w_s2, w_s3, w_s4;
    logic             w_mdu_ready, w_mdu_wr, w_stall, w_issue;

    assign w_src[0] = bus.id_rs;
    assign w_src[1] = bus.id_rt;
    assign w_use    = {bus.id_use_rt, bus.id_use_rs};

    // A slot is a forwarding/write source only if it really writes a nonzero register.
    assign w_ex_wr  = r_ex_valid  & r_ex_reg_write  & (r_ex_rd  != 5'd0);
    assign w_mem_wr = r_mem_valid & r_mem_reg_write & (r_mem_rd != 5'd0);
    assign w_wb_wr  = r_wb_valid  & r_wb_reg_write  & (r_wb_rd  != 5'd0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign w_ex_match[gi]  = w_use[gi] & (w_src[gi] == r_ex_rd);
            assign w_mem_match[gi] = w_use[gi] & (w_src[gi] == r_mem_rd);
            assign w_mdu_match[gi] = w_use[gi] & (w_src[gi] == r_mdu_rd);
            assign w_fwd_next[gi]  = (w_ex_wr  & w_ex_match[gi])  ? 2'b01 :
                                     (w_mem_wr & w_mem_match[gi]) ? 2'b10 : 2'b00;
        end
    endgenerate

    assign w_s1 = r_ex_valid & r_ex_is_load & r_ex_reg_write & (r_ex_rd != 5'd0)
                & (|w_ex_match);
    assign w_s2 = r_mdu_pending & (r_mdu_rd != 5'd0)
                & ((|w_mdu_match) | (bus.id_reg_write & (bus.id_rd == r_mdu_rd)));
    assign w_s3 = bus.id_is_mdu & r_mdu_pending;

    // Pipeline WB owns the write port; a ready MDU result waits and freezes issue.
    assign w_mdu_ready = r_mdu_pending & (r_mdu_cnt == '0);
    assign w_mdu_wr    = ~reset & w_mdu_ready & ~w_wb_wr;
    assign w_s4        = w_mdu_ready & ~w_mdu_wr;

    assign w_stall = ~reset & ~bus.id_flush
                   & ((bus.id_valid & (w_s1 | w_s2 | w_s3)) | w_s4);
    assign w_issue = ~reset & bus.id_valid & ~bus.id_flush & ~w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid    <= 1'b0;
            r_mem_valid   <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_mdu_pending <= 1'b0;
            r_mdu_rd      <= 5'd0;
            r_mdu_cnt     <= '0;
            r_fwd_a       <= 2'b00;
            r_fwd_b       <= 2'b00;
        end else begin
            r_wb_valid      <= r_mem_valid;
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_rd         <= r_mem_rd;
            r_mem_valid     <= r_ex_valid;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_rd        <= r_ex_rd;
            r_ex_valid      <= w_issue;
            if (w_issue) begin
                r_ex_rd        <= bus.id_rd;
                r_ex_reg_write <= bus.id_reg_write & ~bus.id_is_mdu;
                r_ex_is_load   <= bus.id_is_load;
                r_fwd_a        <= w_fwd_next[0];
                r_fwd_b        <= w_fwd_next[1];
            end else begin
                r_fwd_a        <= 2'b00;
                r_fwd_b        <= 2'b00;
            end

            if (w_issue & bus.id_is_mdu) begin
                r_mdu_pending <= 1'b1;
                r_mdu_rd      <= bus.id_rd;
                r_mdu_cnt     <= CNT_LOAD;
            end else begin
                if (w_mdu_wr)
                    r_mdu_pending <= 1'b0;
                if (r_mdu_cnt != '0)
                    r_mdu_cnt <= r_mdu_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.stall    = w_stall;
    assign bus.issue    = w_issue;
    assign bus.fwd_a    = r_fwd_a;
    assign bus.fwd_b    = r_fwd_b;
    assign bus.mdu_busy = r_mdu_pending & ~reset;
    assign bus.mdu_wr   = w_mdu_wr;
    assign bus.mdu_rd   = r_mdu_rd;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed pipeline scenarios plus randomized traffic, every cycle checked against
// a cycle-timestamp model of the scoreboard rules.
module tb_hazard_scoreboard;
    localparam int MDU_LAT = 4;

    typedef struct packed {
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] rd;
        bit       urs;
        bit       urt;
        bit       rw;
        bit       ld;
        bit       mdu;
    } instr_t;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       ld;
    } slot_t;

    logic clk;
    logic reset;
    hazard_scoreboard_if hif();

    hazard_scoreboard #(.MDU_LAT(MDU_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: slots in flight plus MDU completion time in absolute cycles.
    slot_t    m_ex, m_mem, m_wb;
    bit       m_pend;
    bit [4:0] m_mrd;
    int       m_cyc, m_ready_cyc, m_issue_cyc;
    bit [1:0] m_fa, m_fb;

    bit g_issue, g_stall;
    int g_wr_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    function automatic bit uses(input instr_t in, input bit [4:0] r);
        return (r != 0) && ((in.urs && in.rs == r) || (in.urt && in.rt == r));
    endfunction

    function automatic bit [1:0] fwd_of(input bit [4:0] r, input bit u);
        if (u && r != 0 && m_ex.v && m_ex.rw && m_ex.rd == r)   return 2'b01;
        if (u && r != 0 && m_mem.v && m_mem.rw && m_mem.rd == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step(input bit rst, input bit v, input instr_t in, input bit fl);
        bit s1, s2, s3, s4, rdy, wbb, e_mwr, e_stall, e_issue;
        @(negedge clk);
        reset            = rst;
        hif.id_valid     = v;
        hif.id_rs        = in.rs;
        hif.id_rt        = in.rt;
        hif.id_use_rs    = in.urs;
        hif.id_use_rt    = in.urt;
        hif.id_rd        = in.rd;
        hif.id_reg_write = in.rw;
        hif.id_is_load   = in.ld;
        hif.id_is_mdu    = in.mdu;
        hif.id_flush     = fl;
        #1;
        s1      = m_ex.v && m_ex.ld && m_ex.rw && uses(in, m_ex.rd);
        s2      = m_pend && m_mrd != 0 && (uses(in, m_mrd) || (in.rw && in.rd == m_mrd));
        s3      = in.mdu && m_pend;
        rdy     = m_pend && (m_cyc >= m_ready_cyc);
        wbb     = m_wb.v && m_wb.rw && m_wb.rd != 0;
        e_mwr   = !rst && rdy && !wbb;
        s4      = rdy && !e_mwr;
        e_stall = !rst && !fl && ((v && (s1 || s2 || s3)) || s4);
        e_issue = !rst && v && !fl && !e_stall;

        check("stall",    hif.stall,    e_stall);
        check("issue",    hif.issue,    e_issue);
        check("mdu_wr",   hif.mdu_wr,   e_mwr);
        check("mdu_busy", hif.mdu_busy, !rst && m_pend);
        check("mdu_rd",   hif.mdu_rd,   m_mrd);
        check("fwd_a",    hif.fwd_a,    m_fa);
        check("fwd_b",    hif.fwd_b,    m_fb);
        if (e_mwr)
            check("mdu_wr_bound", (m_cyc - m_issue_cyc) <= MDU_LAT + 3, 1);

        g_issue = hif.issue;
        g_stall = hif.stall;
        if (hif.mdu_wr === 1'b1) g_wr_pulses++;

        if (rst) begin
            m_ex.v = 0; m_mem.v = 0; m_wb.v = 0;
            m_pend = 0; m_mrd = 0; m_fa = 0; m_fb = 0;
        end else begin
            m_fa  = e_issue ? fwd_of(in.rs, in.urs) : 2'b00;
            m_fb  = e_issue ? fwd_of(in.rt, in.urt) : 2'b00;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = '{v: e_issue, rd: in.rd, rw: in.rw && !in.mdu, ld: in.ld};
            if (e_mwr) m_pend = 0;
            if (e_issue && in.mdu) begin
                m_pend      = 1;
                m_mrd       = in.rd;
                m_issue_cyc = m_cyc;
                m_ready_cyc = m_cyc + MDU_LAT;
            end
        end
        m_cyc++;
    endtask

    function automatic instr_t alu(input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
        instr_t i = '0;
        i.rd = rd; i.rs = rs; i.rt = rt; i.urs = 1; i.urt = 1; i.rw = 1;
        return i;
    endfunction

    function automatic instr_t lw(input bit [4:0] rd, input bit [4:0] rs);
        instr_t i = '0;
        i.rd = rd; i.rs = rs; i.urs = 1; i.rw = 1; i.ld = 1;
        return i;
    endfunction

    function automatic instr_t mdu(input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
        instr_t i = '0;
        i.rd = rd; i.rs = rs; i.rt = rt; i.urs = 1; i.urt = 1; i.mdu = 1;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int kind = $urandom_range(0, 3);
        i.rs  = 5'($urandom_range(0, 3));
        i.rt  = 5'($urandom_range(0, 3));
        i.rd  = 5'($urandom_range(0, 3));
        i.urs = 1'($urandom);
        i.urt = 1'($urandom);
        i.rw  = (kind == 3) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
        i.ld  = (kind == 1);
        i.mdu = (kind == 2);
        return i;
    endfunction

    task automatic idle();
        step(0, 0, '0, 0);
    endtask

    // Hold the instruction in ID until it issues, as the decode stage would.
    task automatic run_instr(input instr_t in, output int nstall);
        bit done = 0;
        int n = 0;
        for (int k = 0; k < 16 && !done; k++) begin
            step(0, 1, in, 0);
            if (g_issue) done = 1;
            else n++;
        end
        check("issue_within_bound", done, 1);
        nstall = n;
        $display("[TB] cyc %0d rd=%0d rs=%0d rt=%0d ld=%0d mdu=%0d stalls=%0d",
                 m_cyc, in.rd, in.rs, in.rt, in.ld, in.mdu, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     n;
        instr_t cur;
        bit     have, rst, fl;

        m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
        m_pend = 0; m_mrd = 0; m_cyc = 0; m_ready_cyc = 0; m_issue_cyc = 0;
        m_fa = 0; m_fb = 0; g_wr_pulses = 0;
        reset = 1'b1;
        hif.id_valid = 0; hif.id_rs = 0; hif.id_rt = 0; hif.id_use_rs = 0;
        hif.id_use_rt = 0; hif.id_rd = 0; hif.id_reg_write = 0; hif.id_is_load = 0;
        hif.id_is_mdu = 0; hif.id_flush = 0;
        repeat (2) @(posedge clk);
        step(1, 1, alu(1, 2, 3), 0);
        check("rst_stall", g_stall, 0);
        check("rst_issue", g_issue, 0);
        idle();

        // EX->EX forwarding, then MEM forwarding past an independent instruction
        run_instr(alu(3, 1, 2), n);
        run_instr(alu(4, 3, 1), n);
        check("ex_fwd_nostall", n, 0);
        idle();
        check("ex_fwd_a", hif.fwd_a, 2'b01);
        run_instr(alu(3, 1, 2), n);
        run_instr(alu(7, 1, 2), n);
        run_instr(alu(5, 3, 0), n);
        idle();
        check("mem_fwd_a", hif.fwd_a, 2'b10);
        check("zero_fwd_b", hif.fwd_b, 2'b00);

        // Load-use: one bubble, then MEM/WB forwarding on both operands
        run_instr(lw(5, 1), n);
        run_instr(alu(6, 5, 5), n);
        check("lu_stalls", n, 1);
        idle();
        check("lu_fwd_a", hif.fwd_a, 2'b10);
        check("lu_fwd_b", hif.fwd_b, 2'b10);

        // MDU RAW: consumer waits until the result is written
        repeat (3) idle();
        run_instr(mdu(8, 1, 2), n);
        run_instr(alu(9, 8, 0), n);
        check("mdu_raw_stalls", n, MDU_LAT);
        idle();
        check("mdu_raw_fwd_a", hif.fwd_a, 2'b00);

        // MDU write deferred behind two WB writes to $2
        repeat (6) idle();
        g_wr_pulses = 0;
        run_instr(mdu(8, 1, 1), n);
        run_instr(alu(2, 1, 1), n);
        run_instr(alu(2, 1, 1), n);
        idle();
        run_instr(alu(10, 1, 1), n);
        check("drain_stalls", n, 2);
        repeat (6) idle();
        check("drain_wr_pulses", g_wr_pulses, 1);
        check("drain_mdu_rd", hif.mdu_rd, 8);

        // $0 never hazards; second MDU waits for the first to retire
        run_instr(lw(0, 1), n);
        run_instr(alu(6, 0, 0), n);
        check("zero_lu_stalls", n, 0);
        run_instr(mdu(8, 1, 2), n);
        run_instr(mdu(9, 1, 2), n);
        check("mdu_struct_stalls", n, MDU_LAT);
        repeat (8) idle();

        // Reset in the middle of an MDU operation discards the result
        g_wr_pulses = 0;
        run_instr(mdu(11, 1, 1), n);
        idle();
        step(1, 0, '0, 0);
        idle();
        check("rst_mdu_busy", hif.mdu_busy, 0);
        check("rst_fwd_a", hif.fwd_a, 0);
        repeat (8) idle();
        check("rst_no_wr", g_wr_pulses, 0);

        // Flush beats a concurrent load-use stall
        run_instr(lw(5, 1), n);
        step(0, 1, alu(6, 5, 5), 1);
        check("flush_stall", g_stall, 0);
        check("flush_issue", g_issue, 0);
        run_instr(alu(6, 5, 5), n);
        repeat (6) idle();

        // Randomized traffic on a small register range to provoke hazards
        have = 0;
        cur  = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!have) begin
                cur  = rand_instr();
                have = ($urandom_range(0, 4) != 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            fl  = have && ($urandom_range(0, 11) == 0);
            step(rst, have, cur, fl);
            if (g_issue || fl || rst) have = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
